// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory master: state encoding,
// frame geometry and the read/write bit encoding.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int FRAME_LEN = 16;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Command byte {addr, rw} followed by the data byte; reads send zeros.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
    endfunction

endpackage

// File: rtl/spi_mem_if.sv
// Host-side request/response bus of the SPI memory master.
interface spi_mem_if;
    import spi_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/spi_clkgen.sv
// Half-period timer and SCLK phase tracker; emits end-of-half, rise and fall
// strobes one clk cycle ahead of the corresponding SCLK edge.
module spi_clkgen #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic shifting,
    output logic half_end,
    output logic sclk_hi,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;

    assign half_end = run && (cnt_q == 8'd0);
    assign sclk_hi  = shifting && phase_q;
    assign rise     = shifting && half_end && !phase_q;
    assign fall     = shifting && half_end && phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (start) begin
            cnt_d   = RELOAD;
            phase_d = 1'b0;
        end else if (run) begin
            cnt_d = half_end ? RELOAD : cnt_q - 8'd1;
            if (shifting && half_end) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for a byte-wide serial memory: one 16-bit frame
// (command byte {addr, rw}, then data byte) per host request.
//
// state | meaning
// IDLE  | waiting for a request, cs high
// SETUP | cs low, first bit on mosi, one half-period
// SHIFT | 16 SCLK periods, mosi changes on falls, miso sampled on rises
// HOLD  | cs low, sclk low, one half-period after the last fall
// GAP   | cs high for one half-period; response issued on its last cycle
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic     clk,
    input  logic     reset,
    spi_mem_if.slave bus,
    output logic     sclk_pin,
    output logic     cs_pin,
    output logic     mosi_pin,
    input  logic     miso_pin
);

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]      rx_q, rx_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   rw_q, rw_d;
    logic [3:0]             bit_q, bit_d;

    logic accept, half_end, sclk_hi, rise, fall, frame_active;
    logic [DATA_W-1:0] done_data;

    assign accept       = bus.req_valid && (state_q == ST_IDLE);
    assign frame_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign done_data    = (rw_q == RW_READ) ? rx_q : '0;

    spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .run      (state_q != ST_IDLE),
        .shifting (state_q == ST_SHIFT),
        .half_end (half_end),
        .sclk_hi  (sclk_hi),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    tx_d    = build_frame(bus.req_rw, bus.req_addr, bus.req_wdata);
                    rw_d    = bus.req_rw;
                    bit_d   = 4'd0;
                    rx_d    = '0;
                end
            end
            ST_SETUP: if (half_end) state_d = ST_SHIFT;
            ST_SHIFT: begin
                // bit_q is the frame bit currently on the wire; 8..15 are data
                if (rise && (rw_q == RW_READ) && (bit_q >= 4'd8)) begin
                    rx_d = {rx_q[DATA_W-2:0], miso_pin};
                end
                if (fall) begin
                    tx_d = {tx_q[FRAME_LEN-2:0], 1'b0};
                    if (bit_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_HOLD: if (half_end) state_d = ST_GAP;
            ST_GAP: begin
                if (half_end) begin
                    state_d = ST_IDLE;
                    rdata_d = done_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            bit_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_GAP) && half_end;
    // New data appears together with the pulse and is held by rdata_q after it
    assign bus.rsp_rdata = bus.rsp_valid ? done_data : rdata_q;

    assign cs_pin   = !frame_active;
    assign sclk_pin = sclk_hi;
    assign mosi_pin = frame_active ? tx_q[FRAME_LEN-1] : 1'b0;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master with a mode-0 serial memory model,
// response scoreboard and a free-running protocol checker.
module tb_spi_mem_master;
    import spi_mem_pkg::*;

    localparam int CLKDIV = 2;
    localparam int LAT    = 35 * CLKDIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk_pin, cs_pin, mosi_pin;
    logic miso_pin = 1'b0;

    spi_mem_if bus ();

    spi_mem_master #(.CLKDIV(CLKDIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- serial memory model ----------------
    typedef struct {
        logic        rw;
        logic [15:0] frame;
    } frame_t;

    frame_t      exp_frame_q[$];
    frame_t      fr;
    logic [7:0]  mem [0:127];
    logic [7:0]  cmd_byte;
    logic [7:0]  rd_byte;
    logic [15:0] sh;
    int          rises = 0;

    always @(negedge cs_pin) begin
        rises = 0;
        sh    = '0;
    end

    always @(posedge sclk_pin) begin
        if (!cs_pin) begin
            sh = {sh[14:0], mosi_pin};
            rises++;
            if (rises == 8) cmd_byte = sh[7:0];
            if (rises == 16) begin
                chk("frame_expected", 32'(exp_frame_q.size() > 0), 32'd1);
                if (exp_frame_q.size() > 0) begin
                    fr = exp_frame_q.pop_front();
                    chk("mosi_cmd_byte", 32'(sh[15:8]), 32'(fr.frame[15:8]));
                    if (fr.rw == RW_WRITE) chk("mosi_data_byte", 32'(sh[7:0]), 32'(fr.frame[7:0]));
                end
                if (sh[8] == RW_WRITE) mem[sh[15:9]] = sh[7:0];
            end
        end
    end

    always @(negedge sclk_pin) begin
        if (!cs_pin && rises >= 8 && rises < 16 && cmd_byte[0] == RW_READ) begin
            rd_byte  = mem[cmd_byte[7:1]];
            miso_pin = rd_byte[15 - rises];
        end
    end

    // ---------------- scoreboard ----------------
    int         acc_q[$];
    logic [7:0] exp_rdata_q[$];
    int         acc_log[$];
    int         rsp_log[$];
    int         rsp_cnt = 0;
    int         acc_t;
    logic [7:0] exp_rd;

    always @(negedge clk) begin
        if (!reset && bus.req_valid && bus.req_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
        if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_log.push_back(cyc);
            chk("rsp_expected", 32'(acc_q.size() > 0 && exp_rdata_q.size() > 0), 32'd1);
            if (acc_q.size() > 0 && exp_rdata_q.size() > 0) begin
                acc_t  = acc_q.pop_front();
                exp_rd = exp_rdata_q.pop_front();
                chk("latency", 32'(cyc - acc_t), 32'(LAT));
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
            end
        end
    end

    // ---------------- protocol checker ----------------
    logic mosi_prev = 1'b0;
    logic sclk_prev = 1'b0;
    logic cs_prev   = 1'b1;
    logic rst_prev  = 1'b1;
    logic frame_rst = 1'b0;
    logic seen_frame = 1'b0;
    logic [7:0] rdata_prev = 8'h00;
    int   rise_cnt = 0;
    int   cs_hi_run = 0;

    always @(negedge clk) begin
        if (cs_pin) chk("sclk_low_while_cs_high", 32'(sclk_pin), 32'd0);
        if (sclk_pin) chk("mosi_stable_while_sclk_high", 32'(mosi_pin), 32'(mosi_prev));
        if (sclk_pin && !sclk_prev) rise_cnt++;
        if (!cs_pin && cs_prev) begin
            if (seen_frame) chk("cs_high_gap_ge2", 32'(cs_hi_run >= 2), 32'd1);
            rise_cnt  = 0;
            frame_rst = 1'b0;
        end
        if (reset && !cs_prev) frame_rst = 1'b1;
        if (cs_pin && !cs_prev) begin
            if (!frame_rst) chk("rises_per_frame", 32'(rise_cnt), 32'd16);
            seen_frame = 1'b1;
        end
        if (!bus.rsp_valid && !reset && !rst_prev)
            chk("rdata_stable", 32'(bus.rsp_rdata), 32'(rdata_prev));
        cs_hi_run  = cs_pin ? cs_hi_run + 1 : 0;
        mosi_prev  = mosi_pin;
        sclk_prev  = sclk_pin;
        cs_prev    = cs_pin;
        rst_prev   = reset;
        rdata_prev = bus.rsp_rdata;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         input logic [7:0] rd_exp, input logic track);
        frame_t f;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_wdata = d;
        if (track) begin
            f.rw    = rw;
            f.frame = {a, rw, (rw == RW_READ) ? 8'h00 : d};
            exp_frame_q.push_back(f);
            exp_rdata_q.push_back(rd_exp);
        end
    endtask

    task automatic wait_accept(input int n);
        for (int i = 0; i < 200 && acc_log.size() < n; i++) @(negedge clk);
        chk("accept_within_budget", 32'(acc_log.size() >= n), 32'd1);
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = ~bus.req_addr;
        bus.req_wdata = ~bus.req_wdata;
        bus.req_rw    = ~bus.req_rw;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 200 && rsp_cnt < n; i++) @(negedge clk);
        chk("rsp_within_budget", 32'(rsp_cnt >= n), 32'd1);
    endtask

    task automatic txn(input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input logic [7:0] rd_exp);
        int n_acc, n_rsp;
        n_acc = acc_log.size() + 1;
        n_rsp = rsp_cnt + 1;
        drive(rw, a, d, rd_exp, 1'b1);
        wait_accept(n_acc);
        release_req();
        wait_rsp(n_rsp);
        @(negedge clk);
    endtask

    int abort_acc;
    int rsp_before;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        cmd_byte      = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cs", 32'(cs_pin), 32'd1);
        chk("reset_sclk", 32'(sclk_pin), 32'd0);
        chk("reset_mosi", 32'(mosi_pin), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // write then read back the same address
        txn(RW_WRITE, 7'h15, 8'hA5, 8'h00);
        txn(RW_READ,  7'h15, 8'h33, 8'hA5);

        // back-to-back with req_valid held high; second request set up while busy
        drive(RW_WRITE, 7'h7F, 8'h5A, 8'h00, 1'b1);
        wait_accept(3);
        @(posedge clk); #1;
        bus.req_rw    = RW_READ;
        bus.req_addr  = 7'h7F;
        bus.req_wdata = 8'h11;
        exp_frame_q.push_back('{RW_READ, {7'h7F, RW_READ, 8'h00}});
        exp_rdata_q.push_back(8'h5A);
        @(negedge clk);
        chk("busy_during_frame", 32'(bus.busy), 32'd1);
        chk("not_ready_during_frame", 32'(bus.req_ready), 32'd0);
        wait_accept(4);
        release_req();
        wait_rsp(4);
        chk("b2b_accept_after_rsp", 32'(acc_log[3] - rsp_log[2]), 32'd1);

        // boundary address and all-ones data
        txn(RW_WRITE, 7'h00, 8'hFF, 8'h00);
        txn(RW_READ,  7'h00, 8'h00, 8'hFF);

        // reset in the middle of a write aborts it
        drive(RW_WRITE, 7'h15, 8'h3C, 8'h00, 1'b0);
        wait_accept(7);
        abort_acc  = acc_log[6];
        rsp_before = rsp_cnt;
        for (int i = 0; i < 100 && cyc < abort_acc + 20; i++) begin
            @(posedge clk); #1;
        end
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_cs_high", 32'(cs_pin), 32'd1);
        chk("abort_sclk_low", 32'(sclk_pin), 32'd0);
        chk("abort_not_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        acc_q.delete();
        repeat (100) @(negedge clk);
        chk("no_rsp_after_abort", 32'(rsp_cnt), 32'(rsp_before));
        txn(RW_READ, 7'h15, 8'h00, 8'hA5);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_master.md
SPI_MEM_MASTER -- requirements
Module: spi_mem_master

Interface
REQ-001 Parameter: CLKDIV, 4, clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Port: clk  in  1  system clock; all logic on rising edge.
REQ-003 Port: reset  in  1  reset, synchronous and active-high.
REQ-004 Port: req_valid  in  1  host requests a memory transaction.
REQ-005 Port: req_ready  out  1  controller can accept a request; high only in IDLE.
REQ-006 Port: req_rw  in  1  1 = read, 0 = write.
REQ-007 Port: req_addr  in  7  memory address.
REQ-008 Port: req_wdata  in  8  write data; ignored for reads.
REQ-009 Port: rsp_valid  out  1  one-cycle pulse when a transaction completes.
REQ-010 Port: rsp_rdata  out  8  read data; valid with rsp_valid.
REQ-011 Port: busy  out  1  high whenever the state is not IDLE.
REQ-012 Port: sclk_pin  out  1  SPI clock to spimemory; idles low.
REQ-013 Port: cs_pin  out  1  chip select, active-low; idles high.
REQ-014 Port: mosi_pin  out  1  serial data to memory.
REQ-015 Port: miso_pin  in  1  serial data from memory.

Function
REQ-016 The controller SHALL accept a request when req_valid and req_ready are both high; it SHALL latch req_rw, req_addr and req_wdata on that cycle.
REQ-017 The controller SHALL form the command byte as {req_addr[6:0], req_rw}; a frame is 16 bits, MSB first: command byte then data byte.
REQ-018 State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; each non-IDLE state lasts exactly CLKDIV cycles per half-period, counted by a half-period counter.
REQ-019 SETUP: cs_pin low, sclk_pin low, mosi_pin = frame bit 15, for one half-period.
REQ-020 SHIFT: 16 SCLK periods; each period is low-half then high-half; sclk_pin rises at the start of each high half and falls at its end.
REQ-021 mosi_pin SHALL update only on SCLK falling edges, to the next frame bit; it SHALL be stable across every rising edge.
REQ-022 For reads, the controller SHALL sample miso_pin on the clk cycle on which sclk_pin rises for bits 7..0 of the data byte, shifting MSB first; during writes mosi_pin drives req_wdata.
REQ-023 HOLD: cs_pin low, sclk_pin low, for one half-period after the 16th falling edge.
REQ-024 GAP: cs_pin high, for one half-period; on exit rsp_valid pulses for one cycle, concurrent with the return to IDLE.
REQ-025 rsp_rdata SHALL hold the sampled byte for reads, 8'h00 for writes, and remain stable until the next completion.
REQ-026 Latency from the accept cycle to the rsp_valid cycle SHALL be 35*CLKDIV cycles; back-to-back requests SHALL start no sooner than the cycle after rsp_valid.
REQ-027 req_valid while busy SHALL be ignored and not queued; input changes after accept SHALL not affect the frame.
REQ-028 The bit counter SHALL count 0..15 and SHALL not wrap; the half-period counter SHALL reload at CLKDIV-1.

Reset
REQ-029 During reset the state SHALL be IDLE; outputs SHALL be: cs_pin=1, sclk_pin=0, mosi_pin=0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, busy=0.
REQ-030 Reset mid-transaction SHALL abort the frame on the next edge, with no rsp_valid pulse.

Structure
REQ-031 Package spi_mem_pkg SHALL hold the state encoding, the frame length (16), the command/data widths (7, 8) and the RW encoding.
REQ-032 Sub-module spi_clkgen SHALL implement the half-period counter and emit rise/fall strobes; the FSM and shift registers reside in spi_mem_master.

Verification (CLKDIV=2, with the spimemory model attached)
REQ-033 Write addr 0x15, data 0xA5 -> mosi bits 0x2A then 0xA5; rsp_valid at cycle 70 after accept; rsp_rdata=0x00.
REQ-034 Read addr 0x15 after REQ-033 -> command 0x2B; rsp_rdata=0xA5 at cycle 70.
REQ-035 req_valid held high for two requests -> second accepted the cycle after first rsp_valid; cs_pin high at least 2 cycles between frames.
REQ-036 Assert reset at cycle 20 of a write -> cs_pin=1 and sclk_pin=0 the next cycle; no rsp_valid; the following read of that address returns the prior value.
REQ-037 Protocol checker throughout all scenarios -> mosi_pin never changes while sclk_pin is high; exactly 16 SCLK rises per frame; sclk_pin low whenever cs_pin is high.
